btn_conditioner: RTL and testbench



---
 rtl/btn_conditioner_pkg.sv | 24 ++
 rtl/btn_conditioner_if.sv | 20 ++
 rtl/btn_conditioner_channel.sv | 124 ++++++++++++
 rtl/btn_conditioner.sv | 38 +++
 tb/tb_btn_conditioner.sv | 136 +++++++++++++
 5 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared types and default constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int BTN_RESET   = 0;
    localparam int BTN_ENTER   = 1;
    localparam int BTN_RUN     = 2;
    localparam int BTN_PREV    = 3;
    localparam int BTN_NEXT    = 4;
    localparam int BTN_DISPLAY = 5;

    localparam int         N_BTN_DEF           = 6;
    localparam int         DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int         REPEAT_DELAY_DEF    = 50_000_000;
    localparam int         REPEAT_RATE_DEF     = 20_000_000;
    localparam logic [5:0] REPEAT_MASK_DEF     = 6'b011000;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bus between the board inputs and the conditioned pulse outputs.
interface btn_conditioner_if #(
    parameter int N_BTN = 6
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_repeat
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_repeat
    );
endinterface

// File: rtl/btn_conditioner_channel.sv
// One button: two-flop synchroniser, debounce FSM, hold-to-repeat counter.
//   state        | meaning
//   IDLE         | button released and stable
//   PRESS_WAIT   | input high, counting towards accepted press
//   HELD         | press accepted, repeat counter running
//   RELEASE_WAIT | input low, counting towards accepted release
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE     = REPEAT_RATE_DEF,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);

    logic [1:0]    sync;
    logic          s;
    btn_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          press_evt, rel_evt, rpt_evt;
    logic          press_nxt, rel_nxt, rpt_nxt;

    assign s = sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync      <= 2'b00;
            state     <= IDLE;
            cnt       <= '0;
            rcnt      <= '0;
            press_evt <= 1'b0;
            rel_evt   <= 1'b0;
            rpt_evt   <= 1'b0;
        end else begin
            sync      <= {sync[0], raw};
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rcnt      <= rcnt_nxt;
            press_evt <= press_nxt;
            rel_evt   <= rel_nxt;
            rpt_evt   <= rpt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rcnt_nxt  = rcnt;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        rpt_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                    rcnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end else if (rcnt == RPT_FIRE) begin
                    rpt_nxt  = REPEAT_EN;
                    rcnt_nxt = RPT_RELOAD;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            RELEASE_WAIT: begin
                // rcnt is deliberately left alone so a bounce resumes the repeat timing
                if (s) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output stage keeps level aligned with the press/release pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            rpt   <= 1'b0;
        end else begin
            level <= (state == HELD) || (state == RELEASE_WAIT);
            press <= press_evt;
            rel   <= rel_evt;
            rpt   <= rpt_evt;
        end
    end
endmodule

// File: rtl/btn_conditioner.sv
// Conditions the six board push-buttons into level, press, release and repeat strobes.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int               N_BTN           = N_BTN_DEF,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int               REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int               REPEAT_RATE     = REPEAT_RATE_DEF,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(REPEAT_MASK_DEF)
) (
    input logic            clk,
    input logic            reset,
    btn_conditioner_if.slave bus
);
    logic [N_BTN-1:0] level_v, press_v, rel_v, rpt_v;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (bus.btn_raw[i]),
            .level (level_v[i]),
            .press (press_v[i]),
            .rel   (rel_v[i]),
            .rpt   (rpt_v[i])
        );
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = rel_v;
    assign bus.btn_repeat  = rpt_v;
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timing.
module tb_btn_conditioner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   rpt_cnt;
    logic [19:0] pat;

    always #5 clk = ~clk;

    btn_conditioner_if #(.N_BTN(6)) bus ();

    btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int e, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input int e, input logic [5:0] p, input logic [5:0] l,
                        input logic [5:0] r, input logic [5:0] q);
        check({tag, "_press"},   e, bus.btn_press,   p);
        check({tag, "_level"},   e, bus.btn_level,   l);
        check({tag, "_release"}, e, bus.btn_release, r);
        check({tag, "_repeat"},  e, bus.btn_repeat,  q);
    endtask

    initial begin
        bus.btn_raw = '0;
        repeat (3) tick();
        chk4("reset", 0, 6'b0, 6'b0, 6'b0, 6'b0);
        reset = 1'b0;
        repeat (3) tick();

        // clean press on enter, masked so no repeat
        for (int e = 0; e < 46; e++) begin
            bus.btn_raw = (e < 30) ? 6'b000010 : 6'b0;
            tick();
            chk4("clean", e, (e == 7) ? 6'b000010 : 6'b0,
                 (e >= 7 && e < 37) ? 6'b000010 : 6'b0,
                 (e == 37) ? 6'b000010 : 6'b0, 6'b0);
        end

        // bounce on run, final rising sample at edge 20
        pat = 20'b0111_0110_1011_1001_1101;
        for (int e = 0; e < 46; e++) begin
            bus.btn_raw = (e < 20) ? {3'b0, pat[e], 2'b0} : ((e < 35) ? 6'b000100 : 6'b0);
            tick();
            chk4("bounce", e, (e == 27) ? 6'b000100 : 6'b0,
                 (e >= 27 && e < 42) ? 6'b000100 : 6'b0,
                 (e == 42) ? 6'b000100 : 6'b0, 6'b0);
        end

        // auto-repeat on next
        rpt_cnt = 0;
        for (int e = 0; e < 51; e++) begin
            bus.btn_raw = (e < 40) ? 6'b010000 : 6'b0;
            tick();
            if (bus.btn_repeat[4]) rpt_cnt++;
            chk4("autorpt", e, (e == 7) ? 6'b010000 : 6'b0,
                 (e >= 7 && e < 47) ? 6'b010000 : 6'b0,
                 (e == 47) ? 6'b010000 : 6'b0,
                 (e == 17 || e == 22 || e == 27 || e == 32 || e == 37 || e == 42) ? 6'b010000 : 6'b0);
        end
        check("autorpt_count", 0, 6'(rpt_cnt), 6'd6);

        // prev with a 2-cycle dip after the second repeat; rcnt frozen during dip
        rpt_cnt = 0;
        for (int e = 0; e < 53; e++) begin
            bus.btn_raw = (e < 42 && e != 24 && e != 25) ? 6'b001000 : 6'b0;
            tick();
            if (bus.btn_repeat[3]) rpt_cnt++;
            chk4("glitch", e, (e == 7) ? 6'b001000 : 6'b0,
                 (e >= 7 && e < 49) ? 6'b001000 : 6'b0,
                 (e == 49) ? 6'b001000 : 6'b0,
                 (e == 17 || e == 22 || e == 30 || e == 35 || e == 40) ? 6'b001000 : 6'b0);
        end
        check("glitch_count", 0, 6'(rpt_cnt), 6'd5);

        // reset mid-hold on next, button kept high through deassertion
        for (int e = 0; e < 11; e++) begin
            bus.btn_raw = 6'b010000;
            tick();
            chk4("prereset", e, (e == 7) ? 6'b010000 : 6'b0,
                 (e >= 7) ? 6'b010000 : 6'b0, 6'b0, 6'b0);
        end
        #2;
        reset = 1'b1;
        #1;
        chk4("async_reset", 0, 6'b0, 6'b0, 6'b0, 6'b0);
        tick();
        chk4("in_reset", 1, 6'b0, 6'b0, 6'b0, 6'b0);
        #1;
        reset = 1'b0;
        for (int e = 0; e < 13; e++) begin
            tick();
            chk4("postreset", e, (e == 7) ? 6'b010000 : 6'b0,
                 (e >= 7) ? 6'b010000 : 6'b0, 6'b0, 6'b0);
        end
        for (int e = 0; e < 10; e++) begin
            bus.btn_raw = 6'b0;
            tick();
            chk4("postrel", e, 6'b0, (e < 7) ? 6'b010000 : 6'b0,
                 (e == 7) ? 6'b010000 : 6'b0, 6'b0);
        end

        // simultaneous reset and display buttons, both unmasked-off for repeat
        for (int e = 0; e < 26; e++) begin
            bus.btn_raw = (e < 15) ? 6'b100001 : 6'b0;
            tick();
            chk4("simul", e, (e == 7) ? 6'b100001 : 6'b0,
                 (e >= 7 && e < 22) ? 6'b100001 : 6'b0,
                 (e == 22) ? 6'b100001 : 6'b0, 6'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
